// File: rtl/jtag_bsr_chain.sv
// Boundary-scan register chain: capture/shift on rising TCK, update and TDO on falling TCK.
// Each cell is either an input cell (pad -> core) or an output cell (core -> pad), fixed by OUT_MASK.
module jtag_bsr_chain #(
  parameter int                  N_CELLS     = 8,
  parameter logic [N_CELLS-1:0]  OUT_MASK    = '0,
  parameter logic [N_CELLS-1:0]  RESET_VALUE = '0,
  parameter int                  CNT_W       = 8
) (
  input  logic               TCK,
  input  logic               TRST_N,
  input  logic               TDI,
  input  logic               CaptureDR,
  input  logic               ShiftDR,
  input  logic               UpdateDR,
  input  logic [1:0]         Mode,
  input  logic [N_CELLS-1:0] PinIn,
  input  logic [N_CELLS-1:0] CoreIn,
  output logic [N_CELLS-1:0] ToCore,
  output logic [N_CELLS-1:0] ToPin,
  output logic               TDO,
  output logic               TDO_EN,
  output logic [CNT_W-1:0]   ShiftCount
);

  localparam logic [1:0]       MODE_EXTEST = 2'b10;
  localparam logic [1:0]       MODE_INTEST = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [N_CELLS-1:0] shiftReg;
  logic [N_CELLS-1:0] shiftNext;
  logic [N_CELLS-1:0] updateReg;
  logic [N_CELLS-1:0] captureVal;
  logic [CNT_W-1:0]   countReg;
  logic               tdoReg;
  logic               tdoEnReg;

  // Output cells observe the core side, input cells observe the pad side.
  assign captureVal = (CoreIn & OUT_MASK) | (PinIn & ~OUT_MASK);

  // Capture has priority over shift so a Capture+Shift overlap behaves as a capture.
  always_comb begin
    shiftNext = shiftReg;
    if (CaptureDR) begin
      shiftNext = captureVal;
    end else if (ShiftDR) begin
      shiftNext = {TDI, shiftReg[N_CELLS-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      shiftReg <= RESET_VALUE;
      countReg <= '0;
    end else begin
      shiftReg <= shiftNext;
      if (CaptureDR) begin
        countReg <= '0;
      end else if (ShiftDR && (countReg != CNT_MAX)) begin
        countReg <= countReg + 1'b1;
      end
    end
  end

  // Falling-edge stage: parallel update latch and the TDO retiming flop.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      updateReg <= RESET_VALUE;
      tdoReg    <= 1'b0;
      tdoEnReg  <= 1'b0;
    end else begin
      if (UpdateDR) begin
        updateReg <= shiftReg;
      end
      if (ShiftDR) begin
        tdoReg   <= shiftReg[0];
        tdoEnReg <= 1'b1;
      end else begin
        tdoEnReg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CELLS; gi++) begin : gCell
      if (OUT_MASK[gi]) begin : gOut
        assign ToPin[gi]  = (Mode == MODE_EXTEST) ? updateReg[gi] : CoreIn[gi];
        assign ToCore[gi] = 1'b0;
      end else begin : gIn
        assign ToCore[gi] = (Mode == MODE_INTEST) ? updateReg[gi] : PinIn[gi];
        assign ToPin[gi]  = 1'b0;
      end
    end
  endgenerate

  assign TDO        = tdoReg;
  assign TDO_EN     = tdoEnReg;
  assign ShiftCount = countReg;

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// Directed and randomized bench for jtag_bsr_chain (8 cells, upper nibble output cells, 4-bit counter).
// Expected values come from a bit-vector model of the scan rules kept in this file.
module tb_jtag_bsr_chain;

  localparam int         N     = 8;
  localparam logic [7:0] MASK  = 8'hF0;
  localparam logic [7:0] RVAL  = 8'hA5;
  localparam int         CW    = 4;
  localparam int         CMAX  = 15;

  logic       TCK = 1'b0;
  logic       TRST_N;
  logic       TDI;
  logic       CaptureDR;
  logic       ShiftDR;
  logic       UpdateDR;
  logic [1:0] Mode;
  logic [7:0] PinIn;
  logic [7:0] CoreIn;
  logic [7:0] ToCore;
  logic [7:0] ToPin;
  logic       TDO;
  logic       TDO_EN;
  logic [3:0] ShiftCount;

  jtag_bsr_chain #(
    .N_CELLS(N), .OUT_MASK(MASK), .RESET_VALUE(RVAL), .CNT_W(CW)
  ) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TDI(TDI),
    .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
    .Mode(Mode), .PinIn(PinIn), .CoreIn(CoreIn),
    .ToCore(ToCore), .ToPin(ToPin), .TDO(TDO), .TDO_EN(TDO_EN),
    .ShiftCount(ShiftCount)
  );

  always #5 TCK = ~TCK;

  // Reference model state: chain contents, update latch, TDO stage, shift counter.
  logic [7:0] mSr;
  logic [7:0] mUr;
  logic       mTdo;
  logic       mTdoEn;
  int         mCnt;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expToPin();
    return MASK & ((Mode == 2'b10) ? mUr : CoreIn);
  endfunction

  function automatic logic [7:0] expToCore();
    return ~MASK & ((Mode == 2'b11) ? mUr : PinIn);
  endfunction

  task automatic checkAll(input string tag);
    check({tag, ".TDO"},    32'(TDO),        32'(mTdo));
    check({tag, ".TDO_EN"}, 32'(TDO_EN),     32'(mTdoEn));
    check({tag, ".count"},  32'(ShiftCount), 32'(mCnt));
    check({tag, ".ToPin"},  32'(ToPin),      32'(expToPin()));
    check({tag, ".ToCore"}, 32'(ToCore),     32'(expToCore()));
  endtask

  task automatic modelReset();
    mSr = RVAL; mUr = RVAL; mTdo = 1'b0; mTdoEn = 1'b0; mCnt = 0;
  endtask

  // One TAP cycle, entered 1 time unit after a rising edge: strobes are seen by the
  // following falling edge (update/TDO) and then the next rising edge (capture/shift).
  task automatic tapCycle(input bit cap, input bit sh, input bit upd, input bit tdi, input string tag);
    CaptureDR = cap; ShiftDR = sh; UpdateDR = upd; TDI = tdi;
    @(negedge TCK);
    if (upd) mUr = mSr;
    if (sh) begin mTdo = mSr[0]; mTdoEn = 1'b1; end
    else mTdoEn = 1'b0;
    #1 checkAll({tag, ".neg"});
    @(posedge TCK);
    if (cap) begin
      mSr  = (CoreIn & MASK) | (PinIn & ~MASK);
      mCnt = 0;
    end else if (sh) begin
      mSr  = (mSr >> 1) | (8'(tdi) << (N - 1));
      mCnt = (mCnt < CMAX) ? mCnt + 1 : CMAX;
    end
    #1 checkAll({tag, ".pos"});
  endtask

  task automatic shiftByte(input logic [7:0] val, input string tag, output logic [7:0] seen);
    for (int i = 0; i < N; i++) begin
      tapCycle(1'b0, 1'b1, 1'b0, val[i], tag);
      seen[i] = TDO;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench did not complete");
  end

  initial begin
    logic [7:0] seen;
    logic [7:0] capExp;
    logic [7:0] pinHold;

    TRST_N = 1'b0; TDI = 1'b0; CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
    Mode = 2'b00; PinIn = 8'h3C; CoreIn = 8'hC3;
    modelReset();
    #2 checkAll("por");
    @(posedge TCK); #1;
    TRST_N = 1'b1;

    // Reset asserted in the middle of a shift sequence.
    for (int i = 0; i < 3; i++) tapCycle(1'b0, 1'b1, 1'b0, 1'($urandom), "preRst");
    ShiftDR = 1'b1;
    #2 TRST_N = 1'b0;
    Mode = 2'b10;
    modelReset();
    #1 checkAll("midRst");
    check("midRst.ToPinExtest", 32'(ToPin), 32'h0000_00A0);
    Mode = 2'b11; PinIn = 8'h00;
    #1 check("midRst.ToCoreIntest", 32'(ToCore), 32'h0000_0005);
    ShiftDR = 1'b0;
    TRST_N = 1'b1;
    @(posedge TCK); #1;
    shiftByte(8'h00, "rstOut", seen);
    check("rstOut.srValue", 32'(seen), 32'(RVAL));

    // Capture then shift the captured word out.
    Mode = 2'b00; PinIn = 8'h0C; CoreIn = 8'h90;
    capExp = (CoreIn & MASK) | (PinIn & ~MASK);
    tapCycle(1'b1, 1'b0, 1'b0, 1'b0, "cap");
    shiftByte(8'h00, "capOut", seen);
    check("capOut.sequence", 32'(seen), 32'(capExp));
    check("capOut.count8", 32'(ShiftCount), 32'd8);

    // Preload through SAMPLE_PRELOAD, then EXTEST without any clock edge.
    Mode = 2'b01;
    shiftByte(8'h5A, "preload", seen);
    tapCycle(1'b0, 1'b0, 1'b1, 1'b0, "preUpd");
    check("preload.transparent", 32'(ToPin), 32'(CoreIn & MASK));
    Mode = 2'b10;
    #1 check("extest.ToPin", 32'(ToPin), 32'h0000_0050);

    // INTEST drives the update latch into the core for input cells only.
    shiftByte(8'h0F, "intestLoad", seen);
    tapCycle(1'b0, 1'b0, 1'b1, 1'b0, "intestUpd");
    Mode = 2'b11; PinIn = 8'h00;
    #1 check("intest.ToCore", 32'(ToCore), 32'h0000_000F);
    Mode = 2'b00;
    #1 check("functional.ToCore", 32'(ToCore), 32'h0000_0000);

    // Counter saturation and Capture+Shift overlap.
    for (int i = 0; i < 20; i++) tapCycle(1'b0, 1'b1, 1'b0, 1'($urandom), "sat");
    check("sat.count15", 32'(ShiftCount), 32'd15);
    tapCycle(1'b0, 1'b1, 1'b0, 1'b1, "satHold");
    check("satHold.count15", 32'(ShiftCount), 32'd15);
    tapCycle(1'b1, 1'b1, 1'b0, 1'b1, "capShift");
    check("capShift.count0", 32'(ShiftCount), 32'd0);

    // Shifting without UpdateDR must leave the pads alone.
    Mode = 2'b10; CoreIn = 8'h33;
    #1 pinHold = ToPin;
    shiftByte(8'hFF, "noUpd", seen);
    check("noUpd.ToPin", 32'(ToPin), 32'(pinHold));
    check("noUpd.enHigh", 32'(TDO_EN), 32'd1);
    tapCycle(1'b0, 1'b0, 1'b0, 1'b0, "enDrop");
    check("enDrop.TDO_EN", 32'(TDO_EN), 32'd0);

    // Randomized traffic: idle, capture, shift, update, or the tolerated capture+shift overlap.
    for (int i = 0; i < 300; i++) begin
      int op;
      op     = $urandom_range(0, 4);
      Mode   = 2'($urandom);
      PinIn  = 8'($urandom);
      CoreIn = 8'($urandom);
      case (op)
        1:       tapCycle(1'b1, 1'b0, 1'b0, 1'($urandom), "rndCap");
        2:       tapCycle(1'b0, 1'b1, 1'b0, 1'($urandom), "rndShift");
        3:       tapCycle(1'b0, 1'b0, 1'b1, 1'($urandom), "rndUpd");
        4:       tapCycle(1'b1, 1'b1, 1'b0, 1'($urandom), "rndCapShift");
        default: tapCycle(1'b0, 1'b0, 1'b0, 1'($urandom), "rndIdle");
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
